alu_arbiter: RTL

- Shares one combinational `alu` instance (8-bit a/b, 3-bit sel, out/carry/zero) between two requesters.
- Round-robin grant; operands are captured into registers and drive the ALU for one execute cycle.
- The result is registered and returned on a single response channel with a valid/ready handshake and a requester ID.
- Sits between two command sources (e.g. sequencer and debug port) and the `alu`; the `alu` itself is instantiated outside this block.

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter that shares one external combinational ALU
//            between two requesters. A granted command is captured, executed
//            for one cycle on the ALU, and its registered result is returned
//            on a valid/ready response channel tagged with the requester ID.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,

    // Requester 0 command channel
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    // Requester 1 command channel
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    // Shared ALU interface
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,

    // Response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_carry,
    output logic             rsp_zero,

    // Completed-response counters
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] c_CNT_ONE = 8'd1;

    state_t             r_state;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [SEL_W-1:0]   r_op_sel;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_out;
    logic               r_rsp_carry;
    logic               r_rsp_zero;
    logic [7:0]         r_cnt0;
    logic [7:0]         r_cnt1;

    logic               w_any_valid;
    logic               w_grant;
    logic               w_accept;
    logic [WIDTH-1:0]   w_cmd_a;
    logic [WIDTH-1:0]   w_cmd_b;
    logic [SEL_W-1:0]   w_cmd_sel;

    // Round-robin pick: a lone requester wins outright; on a tie the
    // requester that was not served last wins.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
        w_accept = (r_state == ST_IDLE) && w_any_valid;
    end

    // Steer the granted requester's command toward the operand registers.
    always_comb begin
        w_cmd_a   = req0_a;
        w_cmd_b   = req0_b;
        w_cmd_sel = req0_sel;
        if (w_grant) begin
            w_cmd_a   = req1_a;
            w_cmd_b   = req1_b;
            w_cmd_sel = req1_sel;
        end
    end

    // Ready is only offered while idle, so at most one requester sees it.
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    // Operand registers feed the ALU directly and hold between commands.
    assign alu_a   = r_op_a;
    assign alu_b   = r_op_b;
    assign alu_sel = r_op_sel;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_out   = r_rsp_out;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

    // Command lifecycle: capture in IDLE, execute for one cycle, then hold
    // the response until the consumer takes it. Reset drops any command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_sel     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_out    <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a       <= w_cmd_a;
                        r_op_b       <= w_cmd_b;
                        r_op_sel     <= w_cmd_sel;
                        r_last_grant <= w_grant;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The granted ID is still held in r_last_grant.
                    r_rsp_out   <= alu_out;
                    r_rsp_carry <= alu_carry;
                    r_rsp_zero  <= alu_zero;
                    r_rsp_id    <= r_last_grant;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_id) begin
                            r_cnt1 <= r_cnt1 + c_CNT_ONE;
                        end else begin
                            r_cnt0 <= r_cnt0 + c_CNT_ONE;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
